// File: rtl/flash_seq_if.sv
// Signal bundle between the register file / FLASH shifter and the flash_seq command sequencer.
// START is taken only while BUSY=0; SH_WS fires only when SH_BUSY=0, and a byte completes on the first SH_BUSY=0 seen after it.
interface flash_seq_if;
    logic        START;
    logic [7:0]  CMD;
    logic [23:0] ADDR;
    logic        HASADDR;
    logic        WRITE;
    logic [8:0]  LEN;
    logic        POLL;
    logic [7:0]  WDATA;
    logic        WACK;
    logic [7:0]  RDATA;
    logic        RVLD;
    logic        BUSY;
    logic        DONE;
    logic        TMO;
    logic        FCS;
    logic [7:0]  SH_DATA;
    logic        SH_WS;
    logic        SH_BUSY;
    logic [7:0]  SH_RDATA;

    modport master (
        output START, CMD, ADDR, HASADDR, WRITE, LEN, POLL, WDATA, SH_BUSY, SH_RDATA,
        input  WACK, RDATA, RVLD, BUSY, DONE, TMO, FCS, SH_DATA, SH_WS
    );

    modport slave (
        input  START, CMD, ADDR, HASADDR, WRITE, LEN, POLL, WDATA, SH_BUSY, SH_RDATA,
        output WACK, RDATA, RVLD, BUSY, DONE, TMO, FCS, SH_DATA, SH_WS
    );
endinterface

// File: rtl/flash_seq.sv
// FLASH SPI command sequencer: one START becomes a chip-select framed opcode/address/data
// transaction, optionally followed by status polling until write-in-progress clears or times out.
module flash_seq #(
    parameter int POLL_MAX = 65535,
    parameter int CS_GAP   = 8
) (
    input  logic       CLK,
    input  logic       nRST,
    flash_seq_if.slave bus,
    output logic [3:0] dbg_state
);
    localparam logic [15:0] POLL_LIM = POLL_MAX[15:0];
    localparam logic [7:0]  GAP_LD   = CS_GAP[7:0];

    typedef enum logic [3:0] {
        S_IDLE, S_CSON, S_ISSUE, S_WAIT0, S_WAITB, S_GAP, S_PCMD, S_FIN
    } state_t;

    state_t      state;
    logic [7:0]  cmd_r;
    logic [23:0] addr_r;
    logic        hasaddr_r;
    logic        write_r;
    logic        poll_r;
    logic        in_poll;
    logic [9:0]  idx;
    logic [9:0]  last_idx;
    logic [7:0]  gap_cnt;
    logic [15:0] poll_cnt;

    logic [9:0]  data_start;
    logic [9:0]  next_idx;
    logic [9:0]  len_c;
    logic [15:0] poll_inc;
    logic [7:0]  cur_byte;
    logic [7:0]  next_byte;
    logic        cur_wr;
    logic        next_wr;
    logic        rd_data_byte;

    function automatic logic [7:0] pick_byte(input logic [9:0] i, input logic pf,
                                             input logic [7:0] c, input logic [23:0] a,
                                             input logic ha, input logic wr, input logic [7:0] wd);
        logic [7:0] b;
        b = 8'h00;
        if (pf)                     b = (i == 10'd0) ? 8'h05 : 8'h00;
        else if (i == 10'd0)        b = c;
        else if (ha && i == 10'd1)  b = a[23:16];
        else if (ha && i == 10'd2)  b = a[15:8];
        else if (ha && i == 10'd3)  b = a[7:0];
        else if (wr)                b = wd;
        return b;
    endfunction

    // In a poll frame the index parks at 1 so long polls never overflow it.
    always_comb begin
        data_start   = hasaddr_r ? 10'd4 : 10'd1;
        next_idx     = in_poll ? 10'd1 : idx + 10'd1;
        poll_inc     = poll_cnt + 16'd1;
        len_c        = (bus.LEN > 9'd256) ? 10'd256 : {1'b0, bus.LEN};
        cur_byte     = pick_byte(idx, in_poll, cmd_r, addr_r, hasaddr_r, write_r, bus.WDATA);
        next_byte    = pick_byte(next_idx, in_poll, cmd_r, addr_r, hasaddr_r, write_r, bus.WDATA);
        cur_wr       = !in_poll && write_r && (idx >= data_start);
        next_wr      = !in_poll && write_r && (next_idx >= data_start);
        rd_data_byte = !in_poll && !write_r && (idx >= data_start);
    end

    assign dbg_state = state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= S_IDLE;
            cmd_r       <= '0;
            addr_r      <= '0;
            hasaddr_r   <= 1'b0;
            write_r     <= 1'b0;
            poll_r      <= 1'b0;
            in_poll     <= 1'b0;
            idx         <= '0;
            last_idx    <= '0;
            gap_cnt     <= '0;
            poll_cnt    <= '0;
            bus.FCS     <= 1'b1;
            bus.BUSY    <= 1'b0;
            bus.SH_WS   <= 1'b0;
            bus.SH_DATA <= '0;
            bus.WACK    <= 1'b0;
            bus.RVLD    <= 1'b0;
            bus.DONE    <= 1'b0;
            bus.TMO     <= 1'b0;
            bus.RDATA   <= '0;
        end else begin
            bus.SH_WS <= 1'b0;
            bus.WACK  <= 1'b0;
            bus.RVLD  <= 1'b0;
            bus.DONE  <= 1'b0;
            case (state)
                S_IDLE: if (bus.START) begin
                    cmd_r     <= bus.CMD;
                    addr_r    <= bus.ADDR;
                    hasaddr_r <= bus.HASADDR;
                    write_r   <= bus.WRITE;
                    poll_r    <= bus.POLL;
                    last_idx  <= len_c + (bus.HASADDR ? 10'd3 : 10'd0);
                    bus.TMO   <= 1'b0;
                    bus.BUSY  <= 1'b1;
                    state     <= S_CSON;
                end
                S_CSON: begin
                    bus.FCS <= 1'b0;
                    in_poll <= 1'b0;
                    idx     <= '0;
                    state   <= S_ISSUE;
                end
                S_ISSUE: if (!bus.SH_BUSY) begin
                    bus.SH_DATA <= cur_byte;
                    bus.SH_WS   <= 1'b1;
                    bus.WACK    <= cur_wr;
                    state       <= S_WAIT0;
                end
                // The shifter raises SH_BUSY one cycle after WS, so this cycle is blind.
                S_WAIT0: state <= S_WAITB;
                S_WAITB: if (!bus.SH_BUSY) begin
                    logic end_frame;
                    end_frame = 1'b0;
                    if (in_poll) begin
                        if (idx == 10'd0) begin
                            poll_cnt <= '0;
                        end else begin
                            bus.RDATA <= bus.SH_RDATA;
                            poll_cnt  <= poll_inc;
                            if (!bus.SH_RDATA[0]) begin
                                end_frame = 1'b1;
                            end else if (poll_inc == POLL_LIM) begin
                                bus.TMO   <= 1'b1;
                                end_frame = 1'b1;
                            end
                        end
                    end else begin
                        if (rd_data_byte) begin
                            bus.RDATA <= bus.SH_RDATA;
                            bus.RVLD  <= 1'b1;
                        end
                        end_frame = (idx == last_idx);
                    end
                    // Next byte goes out straight from here to keep the gap to one cycle.
                    if (end_frame) begin
                        bus.FCS <= 1'b1;
                        in_poll <= 1'b0;
                        gap_cnt <= GAP_LD;
                        state   <= S_GAP;
                    end else begin
                        idx         <= next_idx;
                        bus.SH_DATA <= next_byte;
                        bus.SH_WS   <= 1'b1;
                        bus.WACK    <= next_wr;
                        state       <= S_WAIT0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        if (poll_r) begin
                            poll_r <= 1'b0;
                            state  <= S_PCMD;
                        end else begin
                            state <= S_FIN;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                S_PCMD: begin
                    bus.FCS  <= 1'b0;
                    in_poll  <= 1'b1;
                    idx      <= '0;
                    poll_cnt <= '0;
                    state    <= S_ISSUE;
                end
                S_FIN: begin
                    bus.DONE <= 1'b1;
                    bus.BUSY <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_seq.sv
// Table-driven bench for flash_seq with a behavioural byte shifter and a per-frame byte scoreboard.
module tb_flash_seq;
    localparam int CS_GAP   = 8;
    localparam int POLL_MAX = 4;
    localparam int SH_LEN   = 6;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [3:0] dbg_state;

    flash_seq_if bus();

    flash_seq #(.POLL_MAX(POLL_MAX), .CS_GAP(CS_GAP)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus), .dbg_state(dbg_state)
    );

    always #4 CLK = ~CLK;

    typedef struct {
        logic [7:0]       cmd;
        logic [23:0]      addr;
        logic             hasaddr;
        logic             write;
        logic [8:0]       len;
        logic             poll;
        logic             poke;
        logic [15:0]      wdata;
        int               n_resp;
        logic [0:9][7:0]  resp;
        int               n_bytes;
        logic [0:9][15:0] exp;
        int               n_rd;
        logic [0:3][7:0]  rd;
        int               n_wack;
        logic             tmo;
        int               frames;
        logic [7:0]       rdata;
    } vec_t;

    vec_t vecs [0:5];

    logic [15:0] exp_q[$];
    logic [15:0] act_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  resp_q[$];
    logic [7:0]  wdata_q[$];

    int   tests = 0;
    int   fails = 0;
    int   wack_cnt, done_cnt, frame_cnt, viol, hi_run, gap_min;
    logic prev_fcs = 1'b1;
    logic prev_ws  = 1'b0;

    // Shifter model: busy for SH_LEN cycles after a write strobe, then presents the reply byte.
    logic       sh_busy  = 1'b0;
    logic [7:0] sh_rdata = 8'h00;
    logic [7:0] pend     = 8'h00;
    int         sh_cnt   = 0;
    assign bus.SH_BUSY  = sh_busy;
    assign bus.SH_RDATA = sh_rdata;

    always @(posedge CLK) begin
        logic [7:0] nb;
        if (bus.SH_WS) begin
            if (resp_q.size() > 0) nb = resp_q.pop_front();
            else nb = 8'hEE;
            pend    <= nb;
            sh_busy <= 1'b1;
            sh_cnt  <= SH_LEN;
        end else if (sh_cnt > 1) begin
            sh_cnt <= sh_cnt - 1;
        end else if (sh_cnt == 1) begin
            sh_cnt   <= 0;
            sh_busy  <= 1'b0;
            sh_rdata <= pend;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock, sampled on the falling edge; also plays the WDATA source.
    task automatic step();
        @(negedge CLK);
        if (bus.SH_WS) begin
            act_q.push_back({frame_cnt[7:0], bus.SH_DATA});
            if (bus.SH_BUSY || prev_ws || bus.FCS) viol++;
        end
        if ((bus.FCS != prev_fcs) && bus.SH_BUSY) viol++;
        if (prev_fcs && !bus.FCS) begin
            if (frame_cnt > 0 && hi_run < gap_min) gap_min = hi_run;
            frame_cnt++;
        end
        if (bus.DONE) begin
            done_cnt++;
            if (hi_run < gap_min) gap_min = hi_run;
        end
        if (bus.RVLD) rd_q.push_back(bus.RDATA);
        if (bus.WACK) begin
            wack_cnt++;
            if (wdata_q.size() > 0) bus.WDATA = wdata_q.pop_front();
            else bus.WDATA = 8'h00;
        end
        if (bus.FCS) hi_run++;
        else hi_run = 0;
        prev_fcs = bus.FCS;
        prev_ws  = bus.SH_WS;
    endtask

    task automatic clear_mon();
        act_q.delete();
        rd_q.delete();
        exp_q.delete();
        wack_cnt  = 0;
        done_cnt  = 0;
        frame_cnt = 0;
        viol      = 0;
        gap_min   = 1000;
    endtask

    task automatic start_cmd(input string tag, input logic [7:0] cmd, input logic [23:0] addr,
                             input logic ha, input logic wr, input logic [8:0] len, input logic poll);
        bus.CMD     = cmd;
        bus.ADDR    = addr;
        bus.HASADDR = ha;
        bus.WRITE   = wr;
        bus.LEN     = len;
        bus.POLL    = poll;
        bus.START   = 1'b1;
        step();
        bus.START = 1'b0;
        check({tag, "_busy_set"}, 32'(bus.BUSY), 32'd1);
        check({tag, "_tmo_clr"}, 32'(bus.TMO), 32'd0);
        check({tag, "_fcs_hi_1"}, 32'(bus.FCS), 32'd1);
        step();
        check({tag, "_fcs_lo_2"}, 32'(bus.FCS), 32'd0);
    endtask

    task automatic wait_done(input logic poke);
        bit poked = 1'b0;
        for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
            if (poke && !poked && act_q.size() >= 3) begin
                poked     = 1'b1;
                bus.START = 1'b1;
                bus.CMD   = 8'hFF;
                bus.LEN   = 9'd0;
            end else begin
                bus.START = 1'b0;
            end
            step();
        end
        bus.START = 1'b0;
        repeat (3) step();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        clear_mon();
        resp_q.delete();
        wdata_q.delete();
        for (int i = 0; i < v.n_resp; i++) resp_q.push_back(v.resp[i]);
        for (int i = 0; i < v.n_bytes; i++) exp_q.push_back(v.exp[i]);
        wdata_q.push_back(v.wdata[7:0]);
        bus.WDATA = v.wdata[15:8];
        start_cmd(tag, v.cmd, v.addr, v.hasaddr, v.write, v.len, v.poll);
        wait_done(v.poke);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_clr"}, 32'(bus.BUSY), 32'd0);
        check({tag, "_fcs_end"}, 32'(bus.FCS), 32'd1);
        check({tag, "_nbytes"}, 32'(act_q.size()), 32'(v.n_bytes));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
        check({tag, "_nrvld"}, 32'(rd_q.size()), 32'(v.n_rd));
        for (int i = 0; i < v.n_rd && i < rd_q.size(); i++)
            check($sformatf("%s_rd%0d", tag, i), 32'(rd_q[i]), 32'(v.rd[i]));
        check({tag, "_nwack"}, 32'(wack_cnt), 32'(v.n_wack));
        check({tag, "_tmo"}, 32'(bus.TMO), 32'(v.tmo));
        check({tag, "_frames"}, 32'(frame_cnt), 32'(v.frames));
        check({tag, "_rdata"}, 32'(bus.RDATA), 32'(v.rdata));
        check({tag, "_protocol"}, 32'(viol), 32'd0);
        check({tag, "_cs_gap"}, 32'(gap_min >= CS_GAP), 32'd1);
    endtask

    initial begin
        // cmd, addr, hasaddr, write, len, poll, poke, wdata, n_resp, resp, n_bytes, {frame,byte}, n_rd, rd, n_wack, tmo, frames, rdata
        vecs[0] = '{8'h03, 24'h123456, 1'b1, 1'b0, 9'd4, 1'b0, 1'b1, 16'h0000,
                    8, {8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00},
                    8, {16'h0103, 16'h0112, 16'h0134, 16'h0156, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0, 16'h0},
                    4, {8'hA1, 8'hB2, 8'hC3, 8'hD4}, 0, 1'b0, 1, 8'hD4};
        vecs[1] = '{8'h02, 24'h010203, 1'b1, 1'b1, 9'd2, 1'b1, 1'b1, 16'h55AA,
                    10, {8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'h03, 8'h03, 8'h00},
                    10, {16'h0102, 16'h0101, 16'h0102, 16'h0103, 16'h0155, 16'h01AA, 16'h0205, 16'h0200, 16'h0200, 16'h0200},
                    0, {8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 2, 8'h00};
        vecs[2] = '{8'hD8, 24'h0F0000, 1'b1, 1'b0, 9'd0, 1'b1, 1'b0, 16'h0000,
                    9, {8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00},
                    9, {16'h01D8, 16'h010F, 16'h0100, 16'h0100, 16'h0205, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0},
                    0, {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b1, 2, 8'h01};
        vecs[3] = '{8'h06, 24'h000000, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 16'h0000,
                    1, {8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    1, {16'h0106, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    0, {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b0, 1, 8'h01};
        vecs[4] = '{8'h9F, 24'hABCDEF, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0, 16'h0000,
                    4, {8'hEE, 8'hEF, 8'h40, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    4, {16'h019F, 16'h0100, 16'h0100, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    3, {8'hEF, 8'h40, 8'h18, 8'h00}, 0, 1'b0, 1, 8'h18};
        vecs[5] = '{8'h42, 24'h000000, 1'b0, 1'b1, 9'd1, 1'b0, 1'b0, 16'h3C00,
                    2, {8'hEE, 8'hEE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    2, {16'h0142, 16'h013C, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                    0, {8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b0, 1, 8'h18};

        // Clock/reset
        nRST        = 1'b0;
        bus.START   = 1'b0;
        bus.CMD     = 8'h00;
        bus.ADDR    = 24'h0;
        bus.HASADDR = 1'b0;
        bus.WRITE   = 1'b0;
        bus.LEN     = 9'd0;
        bus.POLL    = 1'b0;
        bus.WDATA   = 8'h00;
        clear_mon();
        repeat (3) step();
        check("rst_fcs", 32'(bus.FCS), 32'd1);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_sh_ws", 32'(bus.SH_WS), 32'd0);
        check("rst_sh_data", 32'(bus.SH_DATA), 32'd0);
        check("rst_wack", 32'(bus.WACK), 32'd0);
        check("rst_rvld", 32'(bus.RVLD), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_tmo", 32'(bus.TMO), 32'd0);
        check("rst_rdata", 32'(bus.RDATA), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        nRST = 1'b1;
        repeat (2) step();

        for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("v%0d", k));

        // LEN above 256 is clamped: opcode plus 256 write bytes.
        clear_mon();
        resp_q.delete();
        wdata_q.delete();
        for (int i = 1; i < 300; i++) wdata_q.push_back(8'(i));
        bus.WDATA = 8'h00;
        start_cmd("clamp", 8'h02, 24'h0, 1'b0, 1'b1, 9'h1FF, 1'b0);
        wait_done(1'b0);
        check("clamp_done", 32'(done_cnt), 32'd1);
        check("clamp_nbytes", 32'(act_q.size()), 32'd257);
        check("clamp_nwack", 32'(wack_cnt), 32'd256);
        if (act_q.size() == 257) begin
            check("clamp_first", 32'(act_q[0]), 32'h0102);
            check("clamp_mid", 32'(act_q[128]), 32'h017F);
            check("clamp_last", 32'(act_q[256]), 32'h01FF);
        end
        check("clamp_protocol", 32'(viol), 32'd0);

        // Reset while data byte 2 of a read is on the wire.
        clear_mon();
        resp_q.delete();
        start_cmd("mid", 8'h03, 24'h123456, 1'b1, 1'b0, 9'd4, 1'b0);
        for (int c = 0; c < 2000 && act_q.size() < 6; c++) step();
        check("mid_reached", 32'(act_q.size()), 32'd6);
        #2 nRST = 1'b0;
        #1;
        check("mid_rst_fcs", 32'(bus.FCS), 32'd1);
        check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        check("mid_rst_sh_ws", 32'(bus.SH_WS), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        repeat (2) step();
        nRST = 1'b1;
        for (int c = 0; c < 100 && bus.SH_BUSY; c++) step();
        check("mid_sh_idle", 32'(bus.SH_BUSY), 32'd0);
        check("mid_rdata_rst", 32'(bus.RDATA), 32'd0);
        step();
        run_vec(vecs[0], "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
